d_fifo_drain: RTL and testbench

- Downstream consumer of the D0/D1 output FIFOs of the PCIe transaction path.
- Issues pop_D0/pop_D1 and captures the 6-bit words they return, accounting for the FIFOs' one-cycle read latency.
- Arbitrates round-robin between the two FIFOs and presents one word at a time on a valid/ready link to the next stage.
- Keeps saturating per-destination word counters for the control/status logic.

---
 rtl/d_fifo_drain_pkg.sv | 19 +
 rtl/d_fifo_drain_sat_counter.sv | 31 +++
 rtl/d_fifo_drain.sv | 129 ++++++++++++
 tb/tb_d_fifo_drain.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_fifo_drain_pkg.sv
// d_fifo_drain_pkg
//   Shared constants for the D0/D1 output-FIFO drain block.
//   Holds the FSM state encoding, the destination codes and the default
//   widths that must stay in step with the D0/D1 FIFO parameters.
package d_fifo_drain_pkg;

   localparam int D_FIFO_DATA_W  = 6;  // D0/D1 FIFO word width
   localparam int D_FIFO_COUNT_W = 8;  // per-destination word counter width

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } drain_state_t;

   localparam logic DEST_D0 = 1'b0;
   localparam logic DEST_D1 = 1'b1;

endpackage

// File: rtl/d_fifo_drain_sat_counter.sv
// sat_counter
//   Word counter that sticks at all-ones instead of wrapping.
//   A synchronous clear takes priority over a same-cycle increment.
// Ports:
//   clk      clock
//   reset_L  asynchronous active-low reset, count -> 0
//   inc      count one word this cycle
//   clr      synchronous clear, wins over inc
//   count    current count
module sat_counter #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset_L,
   input  logic               inc,
   input  logic               clr,
   output logic [COUNT_W-1:0] count
);

   localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + ONE;
   end

endmodule

// File: rtl/d_fifo_drain.sv
// d_fifo_drain
//   Drains the D0/D1 output FIFOs of the PCIe transaction path onto a
//   valid/ready link, one word at a time, round-robin between the FIFOs,
//   and keeps a saturating word count per destination.
// Ports:
//   clk, reset_L            clock, asynchronous active-low reset
//   enable                  drain permitted (control FSM active)
//   Fifo_Empty_D0/D1        FIFO empty flags
//   data_D0/D1              FIFO read data, valid the cycle after the pop
//   pop_D0/D1               registered one-cycle read strobes
//   out_ready               downstream accepts the presented word
//   out_valid/data/dest     presented word and its source (0=D0, 1=D1)
//   clr_count               synchronous clear of both counters
//   count_D0/D1             words delivered per source, saturating
//   drain_idle              ARB with nothing to do
module d_fifo_drain
   import d_fifo_drain_pkg::*;
#(
   parameter int DATA_W  = D_FIFO_DATA_W,
   parameter int COUNT_W = D_FIFO_COUNT_W
) (
   input  logic               clk,
   input  logic               reset_L,
   input  logic               enable,
   input  logic               Fifo_Empty_D0,
   input  logic               Fifo_Empty_D1,
   input  logic [DATA_W-1:0]  data_D0,
   input  logic [DATA_W-1:0]  data_D1,
   output logic               pop_D0,
   output logic               pop_D1,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_dest,
   input  logic               clr_count,
   output logic [COUNT_W-1:0] count_D0,
   output logic [COUNT_W-1:0] count_D1,
   output logic               drain_idle
);

   localparam int NUM_SRC = 2;

   drain_state_t state;
   logic         last_served;  // source that won the previous arbitration
   logic         sel;          // source of the transfer in flight
   logic         load_wait;    // second LOAD cycle: FIFO data now valid
   logic         pick;
   logic         any_ready;
   logic         accept;

   logic [NUM_SRC-1:0]              inc;
   logic [NUM_SRC-1:0][COUNT_W-1:0] cnt;

   assign any_ready = !Fifo_Empty_D0 || !Fifo_Empty_D1;

   // Single non-empty FIFO wins outright; on a tie the one not served last.
   assign pick = (!Fifo_Empty_D0 && !Fifo_Empty_D1) ? !last_served :
                 (Fifo_Empty_D0 ? DEST_D1 : DEST_D0);

   assign drain_idle = (state == ARB) && (!enable || !any_ready);

   // LOAD lasts two cycles: the pop is high in the first, the FIFO drives
   // the word in the second, and it is captured on the edge closing the
   // second, so out_valid rises with the popped word already in out_data.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state       <= ARB;
         last_served <= DEST_D1;
         sel         <= DEST_D0;
         load_wait   <= 1'b0;
         pop_D0      <= 1'b0;
         pop_D1      <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_dest    <= DEST_D0;
      end else begin
         pop_D0 <= 1'b0;
         pop_D1 <= 1'b0;
         case (state)
            ARB: begin
               if (enable && any_ready) begin
                  sel         <= pick;
                  last_served <= pick;
                  pop_D0      <= (pick == DEST_D0);
                  pop_D1      <= (pick == DEST_D1);
                  load_wait   <= 1'b0;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (!load_wait) begin
                  load_wait <= 1'b1;
               end else begin
                  load_wait <= 1'b0;
                  out_data  <= (sel == DEST_D1) ? data_D1 : data_D0;
                  out_dest  <= sel;
                  out_valid <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   assign accept = (state == SEND) && out_ready;
   assign inc[0] = accept && (out_dest == DEST_D0);
   assign inc[1] = accept && (out_dest == DEST_D1);

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
      sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
         .clk     (clk),
         .reset_L (reset_L),
         .inc     (inc[g]),
         .clr     (clr_count),
         .count   (cnt[g])
      );
   end

   assign count_D0 = cnt[0];
   assign count_D1 = cnt[1];

endmodule

// File: tb/tb_d_fifo_drain.sv
module tb_d_fifo_drain;

   localparam int DW = 6;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic          enable = 1'b0;
   logic          Fifo_Empty_D0, Fifo_Empty_D1;
   logic [DW-1:0] data_D0 = '0, data_D1 = '0;
   logic          pop_D0, pop_D1;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_dest;
   logic          clr_count = 1'b0;
   logic [CW-1:0] count_D0, count_D1;
   logic          drain_idle;

   // FIFO models: empty flags are registered alongside the read data.
   logic          fe0 = 1'b1, fe1 = 1'b1;
   logic          ovr_en = 1'b1, ovr_e0 = 1'b1, ovr_e1 = 1'b1;
   logic [DW-1:0] q0[$], q1[$];
   int            viol = 0, pop0_cnt = 0, pop1_cnt = 0;

   assign Fifo_Empty_D0 = ovr_en ? ovr_e0 : fe0;
   assign Fifo_Empty_D1 = ovr_en ? ovr_e1 : fe1;

   always #5 clk = ~clk;

   d_fifo_drain #(.DATA_W(DW), .COUNT_W(CW)) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .enable        (enable),
      .Fifo_Empty_D0 (Fifo_Empty_D0),
      .Fifo_Empty_D1 (Fifo_Empty_D1),
      .data_D0       (data_D0),
      .data_D1       (data_D1),
      .pop_D0        (pop_D0),
      .pop_D1        (pop_D1),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_dest      (out_dest),
      .clr_count     (clr_count),
      .count_D0      (count_D0),
      .count_D1      (count_D1),
      .drain_idle    (drain_idle)
   );

   always @(posedge clk) begin
      if (pop_D0 && pop_D1) viol++;
      if (pop_D0) begin
         pop0_cnt++;
         if (q0.size() == 0) viol++;
         else data_D0 <= q0.pop_front();
      end
      if (pop_D1) begin
         pop1_cnt++;
         if (q1.size() == 0) viol++;
         else data_D1 <= q1.pop_front();
      end
      fe0 <= (q0.size() == 0);
      fe1 <= (q1.size() == 0);
   end

   typedef struct {
      logic [DW-1:0] data;
      logic          dest;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic en, e0, e1, rdy, clr;
      logic idle;
   } vec_t;
   vec_t vt[8];

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input logic dst);
      exp_t e;
      e.data = d;
      e.dest = dst;
      exp_q.push_back(e);
   endtask

   // Called at a negedge: score a word that the next posedge will accept,
   // then advance one full cycle.
   task automatic tick();
      exp_t e;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", {25'd0, out_dest, out_data}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("word_data", {26'd0, out_data}, {26'd0, e.data});
            chk("word_dest", {31'd0, out_dest}, {31'd0, e.dest});
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_until(input int left, input int budget);
      int n = 0;
      while (exp_q.size() > left && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() > left)
         chk("drain_timeout", exp_q.size(), left);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!out_valid && n < budget) begin
         tick();
         n++;
      end
      chk("wait_valid", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic do_reset();
      reset_L = 1'b0;
      tick();
      reset_L = 1'b1;
      tick();
   endtask

   initial begin
      int p0, p1;
      logic [DW-1:0] held;

      // idle is high whenever enable is low or both FIFOs are empty
      vt[0] = '{en:0, e0:0, e1:0, rdy:1, clr:0, idle:1};
      vt[1] = '{en:0, e0:1, e1:1, rdy:0, clr:1, idle:1};
      vt[2] = '{en:1, e0:1, e1:1, rdy:1, clr:1, idle:1};
      vt[3] = '{en:1, e0:0, e1:1, rdy:0, clr:0, idle:0};
      vt[4] = '{en:1, e0:1, e1:0, rdy:1, clr:0, idle:0};
      vt[5] = '{en:1, e0:0, e1:0, rdy:0, clr:1, idle:0};
      vt[6] = '{en:0, e0:1, e1:0, rdy:1, clr:1, idle:1};
      vt[7] = '{en:1, e0:1, e1:1, rdy:0, clr:0, idle:1};

      // 1. reset held with inputs toggling
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         enable    = vt[i].en;
         ovr_e0    = vt[i].e0;
         ovr_e1    = vt[i].e1;
         out_ready = vt[i].rdy;
         clr_count = vt[i].clr;
         #1;
         chk($sformatf("rst_idle[%0d]", i), {31'd0, drain_idle}, {31'd0, vt[i].idle});
         chk($sformatf("rst_outs[%0d]", i),
             {18'd0, pop_D0, pop_D1, out_valid, out_data, out_dest, count_D0, count_D1}, 32'd0);
         @(negedge clk);
      end
      ovr_en    = 1'b0;
      clr_count = 1'b0;
      out_ready = 1'b0;
      enable    = 1'b1;
      reset_L   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("empty_no_pop", {30'd0, pop_D0, pop_D1}, 32'd0);
      end
      chk("empty_idle", {31'd0, drain_idle}, 32'd1);

      // 2. single source D0
      p0 = pop0_cnt; p1 = pop1_cnt;
      q0.push_back(6'h15); q0.push_back(6'h2A);
      push_exp(6'h15, 1'b0); push_exp(6'h2A, 1'b0);
      out_ready = 1'b1;
      run_until(0, 40);
      chk("t2_pop0", pop0_cnt - p0, 2);
      chk("t2_pop1", pop1_cnt - p1, 0);
      chk("t2_count_D0", {30'd0, count_D0}, 32'd2);
      chk("t2_count_D1", {30'd0, count_D1}, 32'd0);

      // 3. round-robin from a fresh reset (D0 wins the first tie)
      do_reset();
      q0.push_back(6'h01); q0.push_back(6'h02);
      q1.push_back(6'h31); q1.push_back(6'h32);
      push_exp(6'h01, 1'b0); push_exp(6'h31, 1'b1);
      push_exp(6'h02, 1'b0); push_exp(6'h32, 1'b1);
      run_until(0, 60);
      chk("t3_count_D0", {30'd0, count_D0}, 32'd2);
      chk("t3_count_D1", {30'd0, count_D1}, 32'd2);

      // 4. backpressure
      clr_count = 1'b1; tick(); clr_count = 1'b0;
      chk("clr_both", {28'd0, count_D0, count_D1}, 32'd0);
      out_ready = 1'b0;
      q1.push_back(6'h2C);
      push_exp(6'h2C, 1'b1);
      wait_valid(10);
      q0.push_back(6'h07);
      push_exp(6'h07, 1'b0);
      p0 = pop0_cnt; p1 = pop1_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", {24'd0, out_valid, out_dest, out_data}, {24'd0, 1'b1, 1'b1, 6'h2C});
         chk("bp_count", {28'd0, count_D0, count_D1}, 32'd0);
      end
      chk("bp_no_pop", (pop0_cnt - p0) + (pop1_cnt - p1), 0);
      out_ready = 1'b1;
      run_until(1, 5);
      chk("bp_single_accept", {28'd0, count_D0, count_D1}, 32'd1);
      run_until(0, 20);
      chk("bp_count_D0", {30'd0, count_D0}, 32'd1);

      // 5. saturation, then clear on an accept cycle
      for (int i = 0; i < 5; i++) begin
         q1.push_back(6'(6'h10 + i));
         push_exp(6'(6'h10 + i), 1'b1);
      end
      run_until(0, 60);
      chk("sat_count_D1", {30'd0, count_D1}, 32'd3);
      out_ready = 1'b0;
      q1.push_back(6'h20);
      push_exp(6'h20, 1'b1);
      wait_valid(10);
      out_ready = 1'b1;
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      out_ready = 1'b0;
      chk("clr_beats_inc", {30'd0, count_D1}, 32'd0);
      chk("clr_accept_done", {31'd0, out_valid}, 32'd0);

      // 6. async reset while a D0 word waits in SEND (last_served = D0)
      q0.push_back(6'h05);
      q1.push_back(6'h36);
      wait_valid(10);
      chk("t6_pre_word", {25'd0, out_dest, out_data}, {25'd0, 1'b0, 6'h05});
      #2 reset_L = 1'b0;
      #1;
      chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_async_data", {26'd0, out_data}, 32'd0);
      @(negedge clk);
      q0.push_back(6'h06);
      tick();
      reset_L   = 1'b1;
      out_ready = 1'b1;
      push_exp(6'h06, 1'b0); push_exp(6'h36, 1'b1);
      run_until(0, 40);

      chk("no_pop_violation", viol, 0);
      chk("fifos_drained", q0.size() + q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
